// File: rtl/controller_reader_if.sv
// Bus bundle between the CPU-side read mux / controller pads and the
// controller_reader block. The slave modport is the reader itself; the
// master modport is everything around it (CPU, address decoder, pads).
interface controller_reader_if;
    // Poll request / status
    logic       start;
    logic       busy;

    // CPU read window
    logic       SELECT_controller;
    logic       cpu_address_lsb;
    logic       write_enable;
    logic [7:0] data_out;
    logic       data_out_enable;

    // Pad-side serial lines
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic       ctrl_data_1;
    logic       ctrl_data_2;

    modport slave (
        input  start,
        input  SELECT_controller,
        input  cpu_address_lsb,
        input  write_enable,
        input  ctrl_data_1,
        input  ctrl_data_2,
        output busy,
        output data_out,
        output data_out_enable,
        output ctrl_latch,
        output ctrl_clk
    );

    modport master (
        output start,
        output SELECT_controller,
        output cpu_address_lsb,
        output write_enable,
        output ctrl_data_1,
        output ctrl_data_2,
        input  busy,
        input  data_out,
        input  data_out_enable,
        input  ctrl_latch,
        input  ctrl_clk
    );
endinterface

// File: rtl/controller_reader.sv
// controller_reader: polls two NES-style pads once per start pulse.
// Drives the shared latch/clock lines, shifts in eight active-low button
// bits from each pad (A first into bit 0, Right last into bit 7), then
// commits both bytes in one cycle so the CPU never reads a half-shifted
// value. The CPU read path is purely combinational.
module controller_reader #(
    parameter int HALF_PERIOD = 76   // cycles per latch pulse / clock half-phase, 4..255
) (
    input  logic                 clk_12_5875,
    input  logic                 rst_B,
    controller_reader_if.slave   bus
);

    localparam int               CNT_W    = $clog2(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        COMMIT
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;

    logic [1:0]       sync_1, sync_2;
    logic [7:0]       shift_1, shift_2;
    logic [7:0]       pad1_reg, pad2_reg;

    logic             sample;     // last cycle of LOW: capture one bit per pad
    logic             commit;     // COMMIT cycle: publish both bytes
    logic             cnt_zero;

    logic             latch_q, clk_q, busy_q;

    // Two-flop synchronizers for the asynchronous pad data lines.
    // NOTE: these reset to 1 (the idle level of an active-low line) so a
    // reset never looks like a pressed button; every flop in this block has
    // an explicit reset value, including the shift registers.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            sync_1 <= 2'b11;
            sync_2 <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments keep each flop reading the
            // previous-cycle value of its neighbour, which is what makes
            // this a two-stage chain rather than a single wire.
            sync_1 <= {sync_1[0], bus.ctrl_data_1};
            sync_2 <= {sync_2[0], bus.ctrl_data_2};
        end
    end

    // State, phase counter and bit index registers.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
        end
    end

    assign cnt_zero = (cnt == '0);

    // Next-state logic: each timed phase counts down from HALF_PERIOD-1.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        next_state   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        sample       = 1'b0;
        commit       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state   = LATCH;
                    cnt_next     = CNT_LOAD;
                    bit_idx_next = 3'd0;
                end
            end

            LATCH: begin
                if (cnt_zero) begin
                    next_state = LOW;
                    cnt_next   = CNT_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            LOW: begin
                if (cnt_zero) begin
                    sample   = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (bit_idx == 3'd7) begin
                        // Eighth bit captured: no trailing clock pulse.
                        next_state = COMMIT;
                    end else begin
                        next_state   = HIGH;
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            HIGH: begin
                if (cnt_zero) begin
                    next_state = LOW;
                    cnt_next   = CNT_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            COMMIT: begin
                // start is deliberately not looked at here: no queued polls.
                commit     = 1'b1;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift registers: invert the active-low pad data so pressed reads as 1.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            shift_1 <= 8'h00;
            shift_2 <= 8'h00;
        end else if (sample) begin
            shift_1[bit_idx] <= ~sync_1[1];
            shift_2[bit_idx] <= ~sync_2[1];
        end
    end

    // Committed button bytes: updated together, only in COMMIT.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            pad1_reg <= 8'h00;
            pad2_reg <= 8'h00;
        end else if (commit) begin
            pad1_reg <= shift_1;
            pad2_reg <= shift_2;
        end
    end

    // Registered pad-line and status outputs, decoded from the next state so
    // they change on the same edge as the state register without glitches.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            latch_q <= 1'b0;
            clk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            latch_q <= (next_state == LATCH);
            clk_q   <= (next_state == HIGH);
            busy_q  <= (next_state != IDLE);
        end
    end

    assign bus.ctrl_latch = latch_q;
    assign bus.ctrl_clk   = clk_q;
    assign bus.busy       = busy_q;

    // Combinational CPU read path; writes to the window are simply ignored.
    always_comb begin
        bus.data_out_enable = bus.SELECT_controller & ~bus.write_enable;
        if (bus.data_out_enable) begin
            bus.data_out = bus.cpu_address_lsb ? pad2_reg : pad1_reg;
        end else begin
            bus.data_out = 8'h00;
        end
    end

endmodule

// File: doc/controller_reader.md
# controller_reader

Serial front end for the two NES-style game controllers on the console board. When pulsed once per frame, it drives the controller latch and clock lines, shifts in 8 button bits from each pad, and commits both bytes atomically. It then returns those bytes to the CPU data bus whenever the address decoder asserts the controller select. It sits directly downstream of the address decoder's controller select and replaces the off-chip controller latch, sharing the FPGA's read-data mux with firmware and GPU.

## Interface
Parameters:
- HALF_PERIOD, default 76: clk cycles per latch pulse and per clock half-phase (about 6.04 us at 12.5875 MHz). Legal range 4..255.

Ports:
- clk_12_5875  input  1  system clock; the only clock.
- rst_B  input  1  reset; asynchronous and active-low.
- start  input  1  one-cycle pulse requesting a poll, typically at vblank entry.
- SELECT_controller  input  1  address decoder select for the controller window.
- cpu_address_lsb  input  1  CPU address bit 0: 0 selects pad 1, 1 selects pad 2.
- write_enable  input  1  active-high CPU write strobe.
- data_out  output  8  read data to the CPU bus mux.
- data_out_enable  output  1  high when data_out is to be driven onto the bus.
- ctrl_latch  output  1  shared latch line to both pads.
- ctrl_clk  output  1  shared serial clock to both pads.
- ctrl_data_1, ctrl_data_2  input  1 each  serial data from the pads, asynchronous, active-low (0 = pressed).
- busy  output  1  high while a poll is in progress.

## Operation
- ctrl_data_1 and ctrl_data_2 each pass through a 2-flop synchronizer before use. Synchronizer flops reset to 1.
- State machine states: IDLE, LATCH, LOW, HIGH, COMMIT.
  - IDLE: outputs low. On start, load the cycle counter, clear bit_idx, and go to LATCH.
  - LATCH: ctrl_latch=1 for HALF_PERIOD cycles, then go to LOW.
  - LOW: ctrl_latch=0 and ctrl_clk=0 for HALF_PERIOD cycles. On the last cycle, sample both synchronized inputs, invert them, and write them into shift bit [bit_idx]. Then:
    - if bit_idx==7, go to COMMIT;
    - otherwise increment bit_idx and go to HIGH.
  - HIGH: ctrl_clk=1 for HALF_PERIOD cycles, then go to LOW.
  - COMMIT: copy both shift registers into pad1_reg and pad2_reg in a single cycle, then go to IDLE.
- Bit order: the first bit read (A) lands in bit 0. The remaining bits follow in order: B, Select, Start, Up, Down, Left, Right, with Right in bit 7. Pressed reads as 1.
- pad1_reg and pad2_reg change only in COMMIT. The CPU never sees a partially shifted byte.
- busy=1 in every state except IDLE.
- start is ignored in every state except IDLE, including the COMMIT cycle. There is no queueing.
- Read path is combinational:
  - data_out_enable = SELECT_controller & ~write_enable.
  - data_out = cpu_address_lsb ? pad2_reg : pad1_reg when enabled, otherwise 8'h00.
- CPU writes to the controller window have no effect.
- Cycle counter width is $clog2(HALF_PERIOD). bit_idx is 3 bits. Neither wraps inside a poll.

## Timing
- Reset values:
  - data_out = 8'h00; data_out_enable follows its inputs.
  - ctrl_latch = 0, ctrl_clk = 0, busy = 0.
  - pad1_reg = pad2_reg = 8'h00; shift registers = 8'h00.
  - State = IDLE.
- ctrl_latch and ctrl_clk are registered outputs.
- Timeline, with start sampled high on cycle 0:
  - busy and ctrl_latch rise on cycle 1.
  - ctrl_latch falls on cycle 1+H.
- Per-poll counts:
  - ctrl_clk produces exactly 7 rising edges.
  - pad1_reg and pad2_reg update at the end of the COMMIT cycle, 16*H+1 cycles after entering LATCH.
  - busy falls the cycle after COMMIT.
- Input sampling: pad data is sampled H cycles after the preceding latch fall or clk fall. The 2-flop synchronizer delay (2 cycles) is well inside H, since H>=4.
- Read latency: zero cycles. data_out settles combinationally from the select and address inputs.
- Reset asserted mid-poll: outputs drop immediately (asynchronously). Committed registers clear to 0. The poll is abandoned, and no commit occurs after reset release.

## Test plan
- Reset: assert rst_B=0 mid-LATCH -> ctrl_latch=0, ctrl_clk=0, busy=0 immediately; after release with no start, busy stays 0 for 2000 cycles.
- Full poll, H=76: pad 1 drives 0 on bits A and Right, pad 2 drives 0 on Start only -> exactly 7 ctrl_clk rising edges; commit occurs 1217 cycles after LATCH entry; pad1_reg=8'h81, pad2_reg=8'h08.
- CPU read after that poll: SELECT_controller=1, write_enable=0, lsb=0 -> data_out=8'h81, data_out_enable=1; lsb=1 -> 8'h08; write_enable=1 -> data_out_enable=0, data_out=8'h00.
- Atomicity: a previous value of 8'h81 is held while a new poll shifts in 8'h00 -> reads through the final LOW state return 8'h81; the cycle after COMMIT reads 8'h00.
- Start pulses while busy, including on the COMMIT cycle -> ignored; exactly one commit results, with no extra ctrl_latch pulse.
- Bench with H=4: one poll takes 65 cycles from LATCH entry to the end of commit, and data sampled with all-zero serial inputs gives 8'hFF on both pads.
